// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - gated frequency counter: rising edges of sig_in per GATE_CYCLES clk window
module freq_meter #(
  parameter int GATE_CYCLES = 100_000_000,
  parameter int CNT_W       = 27,
  parameter int GATE_W      = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             en,
  output logic [CNT_W-1:0] freq,
  output logic             valid,
  output logic             ovf,
  output logic             busy
);

  typedef enum logic {IDLE, MEAS} state_t;

  localparam logic [CNT_W-1:0]  ECNT_MAX  = '1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

  state_t            state, state_nxt;
  logic              s1, s2, s3;
  logic              edge_p;
  logic [GATE_W-1:0] gcnt, gcnt_nxt;
  logic [CNT_W-1:0]  ecnt, ecnt_nxt, ecnt_fin;
  logic              sat, sat_nxt;
  logic              drop;
  logic              win_end;

  // Synchronizer and edge-delay flop run continuously so the edge history is
  // already settled when a window opens.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign edge_p = s2 & ~s3;

  // An edge arriving while the counter is already full is dropped and flagged.
  assign drop     = (ecnt == ECNT_MAX) & edge_p;
  assign ecnt_fin = drop ? ecnt : ecnt + CNT_W'(edge_p);

  assign busy = (state == MEAS);

  // Next-state and counter update; the last window cycle publishes regardless
  // of en, so en only aborts windows that have not yet reached their last cycle.
  always_comb begin
    state_nxt = state;
    gcnt_nxt  = '0;
    ecnt_nxt  = '0;
    sat_nxt   = 1'b0;
    win_end   = 1'b0;
    case (state)
      IDLE: begin
        if (en) state_nxt = MEAS;
      end
      MEAS: begin
        if (gcnt == GATE_LAST) begin
          win_end = 1'b1;
          if (!en) state_nxt = IDLE;
        end else if (!en) begin
          state_nxt = IDLE;
        end else begin
          gcnt_nxt = gcnt + 1'b1;
          ecnt_nxt = ecnt_fin;
          sat_nxt  = sat | drop;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and window counters; cleared counters double as the next window's start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gcnt  <= '0;
      ecnt  <= '0;
      sat   <= 1'b0;
    end else begin
      state <= state_nxt;
      gcnt  <= gcnt_nxt;
      ecnt  <= ecnt_nxt;
      sat   <= sat_nxt;
    end
  end

  // Result registers change only together with the valid pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      freq  <= '0;
      ovf   <= 1'b0;
      valid <= 1'b0;
    end else begin
      valid <= win_end;
      if (win_end) begin
        freq <= ecnt_fin;
        ovf  <= sat | drop;
      end
    end
  end

endmodule
